dp_ctrl: RTL and testbench
==========================

# dp_ctrl

Multi-cycle control unit for ARM-style data-processing instructions. It accepts one 32-bit instruction word over a valid/ready handshake and evaluates its condition field against the architectural NZCV register it owns. It drives the ALU's `ALU_OP`/`S`/`C`/`V` inputs and captures the ALU's `F`/`NZCV` outputs. It then issues the register-file writeback and flag update, so it is the driving end of the ALU interface.

## Interface
- No parameters; all widths are fixed by the ISA.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ir_valid` in 1: instruction word present.
- `ir` in 32: instruction word.
- `ir_ready` out 1: high only in IDLE.
- `ALU_OP` out 4: ALU operation select.
- `S` out 1: ALU flag-compute enable.
- `C`, `V` out 1 each: current CPSR C and V, fed to the ALU.
- `alu_F` in 32: ALU result.
- `alu_NZCV` in 4: ALU flags.
- `rn_addr`, `rm_addr`, `rd_addr` out 4 each: `ir[19:16]`, `ir[3:0]`, `ir[15:12]`.
- `op_imm` out 1 / `imm12` out 12: `ir[25]` / `ir[11:0]`, for the operand-2 path.
- `rf_we` out 1 / `rf_wdata` out 32: register-file write.
- `cpsr_nzcv` out 4: architectural flags.
- `done` out 1: one-cycle pulse per instruction.
- `executed` out 1: qualifies `done`.
- `illegal` out 1: qualifies `done`.

## Operation
- Instruction fields:
  - `cond` = `ir[31:28]`
  - class = `ir[27:26]`; must be 00, otherwise the instruction is illegal
  - `opc` = `ir[24:21]`
  - `s` = `ir[20]`
- Opcode to `ALU_OP` mapping:
  - AND→0, EOR→1, SUB→2, RSB→3, ADD→4, ADC→5, SBC→6, RSC→7 (write Rd)
  - TST→0, TEQ→1, CMP→2, CMN→4 (no Rd write; `S` forced to 1)
  - ORR→C, MOV→D, BIC→E, MVN→F (write Rd)
- Condition evaluation (standard ARM encodings) against `cpsr_nzcv`:
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V
  - HI C&!Z; LS !C|Z
  - GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V)
  - AL 1; 1111 = never
- FSM states: IDLE, DECODE, EXEC, WB.
  - IDLE→DECODE on `ir_valid & ir_ready`; `ir` is latched into the instruction register.
  - DECODE: compute `pass = legal & cond_ok`. If pass, go to EXEC; else go to WB with `executed=0`.
  - EXEC: drive `ALU_OP`, `S`, `C`, `V`. At the exiting edge, latch `alu_F` into the result register and `alu_NZCV` into the flag register.
  - WB → IDLE unconditionally.
- WB outputs:
  - `done=1`; `executed=pass`; `illegal=!legal`.
  - `rf_we = pass & writes_rd`; `rf_wdata` = latched F.
  - `cpsr_nzcv` is loaded from the latched flags at the WB exit edge if `pass & S`.
- Outside EXEC: `ALU_OP=0`, `S=0`. `C`/`V` always mirror `cpsr_nzcv[1]`/`[0]`.
- Register-address and immediate outputs are continuously decoded from the latched instruction register.

## Timing
- Reset values:
  - state IDLE, `ir_ready=1`
  - instruction register 0, result 0, `cpsr_nzcv=0000`
  - `ALU_OP=0`, `S=0`, `rf_we=0`, `rf_wdata=0`
  - `done=0`, `executed=0`, `illegal=0`
- Latency: handshake edge t; DECODE t+1; EXEC t+2; WB t+3 (`done`, `rf_we`); IDLE t+4.
  - Throughput: one instruction per 4 cycles.
  - A failed or illegal instruction skips EXEC: `done` at t+2, IDLE at t+3.
- The ALU is combinational; `alu_F`/`alu_NZCV` are sampled only at the EXEC exit edge.
- Flags written by instruction k are visible to the condition check of instruction k+1; there is no hazard window.
- `ir_valid` held high while `ir_ready=0` is ignored; the word is re-sampled at the next IDLE.
- `rst_n` low in any state aborts immediately: no `rf_we` or flag write occurs, and all registers return to reset values.

## Structure
- Package `dp_pkg`: ALU_OP localparams (AND..MVN), cond-code localparams, FSM state encoding, and NZCV bit indices N=3, Z=2, C=1, V=0.
- Sub-module `cond_eval`: combinational; inputs `cond[3:0]` and `nzcv[3:0]`; output `pass`.
- Top level holds the FSM, instruction register, result/flag latches and the CPSR.

## Test plan
- ADD with set flags: `ir`=0xE0921003 (ADDS R1,R2,R3); `alu_F`=5, `alu_NZCV`=0000 → at t+2 `ALU_OP`=4, `S`=1; at t+3 `rf_we`=1, `rd_addr`=1, `rf_wdata`=5, `done`=1, `executed`=1; `cpsr_nzcv`=0000.
- CMP then conditional MOV, Z set: 0xE1500001 (CMP R0,R1) with `alu_NZCV`=0100 → no `rf_we`, `cpsr_nzcv`=0100. Then 0x01A02003 (MOVEQ R2) → `ALU_OP`=D, `S`=0, `rf_we`=1, `rd_addr`=2.
- Same MOVEQ with `cpsr_nzcv`=0000 → `done` at t+2, `executed`=0, `rf_we`=0, EXEC never entered.
- Illegal class: `ir`=0xEA000000 → `done`=1, `illegal`=1, `executed`=0, no write, back in IDLE at t+3.
- Back-to-back: `ir_valid` held high for 3 ADDs → `ir_ready` pulses every 4 cycles; exactly 3 `done` pulses.
- Reset mid-operation: `rst_n` low during EXEC of ADDS → `rf_we` never asserts, `cpsr_nzcv`=0000, `ir_ready`=1 immediately.

Source files
------------

// File: rtl/dp_pkg.sv
// dp_pkg: shared encodings for the data-processing control unit
package dp_pkg;
    localparam logic [3:0] ALU_AND = 4'h0;
    localparam logic [3:0] ALU_EOR = 4'h1;
    localparam logic [3:0] ALU_SUB = 4'h2;
    localparam logic [3:0] ALU_RSB = 4'h3;
    localparam logic [3:0] ALU_ADD = 4'h4;
    localparam logic [3:0] ALU_ADC = 4'h5;
    localparam logic [3:0] ALU_SBC = 4'h6;
    localparam logic [3:0] ALU_RSC = 4'h7;
    localparam logic [3:0] ALU_ORR = 4'hC;
    localparam logic [3:0] ALU_MOV = 4'hD;
    localparam logic [3:0] ALU_BIC = 4'hE;
    localparam logic [3:0] ALU_MVN = 4'hF;
    localparam logic [3:0] CC_EQ = 4'h0;
    localparam logic [3:0] CC_NE = 4'h1;
    localparam logic [3:0] CC_CS = 4'h2;
    localparam logic [3:0] CC_CC = 4'h3;
    localparam logic [3:0] CC_MI = 4'h4;
    localparam logic [3:0] CC_PL = 4'h5;
    localparam logic [3:0] CC_VS = 4'h6;
    localparam logic [3:0] CC_VC = 4'h7;
    localparam logic [3:0] CC_HI = 4'h8;
    localparam logic [3:0] CC_LS = 4'h9;
    localparam logic [3:0] CC_GE = 4'hA;
    localparam logic [3:0] CC_LT = 4'hB;
    localparam logic [3:0] CC_GT = 4'hC;
    localparam logic [3:0] CC_LE = 4'hD;
    localparam logic [3:0] CC_AL = 4'hE;
    localparam logic [3:0] CC_NV = 4'hF;
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;
    typedef enum logic [1:0] {ST_IDLE, ST_DECODE, ST_EXEC, ST_WB} state_t;
endpackage

// File: rtl/cond_eval.sv
// cond_eval: ARM condition-code check against NZCV
module cond_eval
    import dp_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);
    logic w_n, w_z, w_c, w_v, w_base;
    assign w_n = nzcv[FLAG_N];
    assign w_z = nzcv[FLAG_Z];
    assign w_c = nzcv[FLAG_C];
    assign w_v = nzcv[FLAG_V];
    // Even codes test a predicate; each odd code is its complement (AL/NV included)
    always_comb begin
        w_base = 1'b1;
        case ({cond[3:1], 1'b0})
            CC_EQ:   w_base = w_z;
            CC_CS:   w_base = w_c;
            CC_MI:   w_base = w_n;
            CC_VS:   w_base = w_v;
            CC_HI:   w_base = w_c & !w_z;
            CC_GE:   w_base = w_n == w_v;
            CC_GT:   w_base = !w_z & (w_n == w_v);
            default: w_base = 1'b1;
        endcase
    end
    assign pass = w_base ^ cond[0];
endmodule

// File: rtl/dp_ctrl.sv
// dp_ctrl: multi-cycle control for ARM data-processing instructions
module dp_ctrl
    import dp_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ir_valid,
    input  logic [31:0] ir,
    output logic        ir_ready,
    output logic [3:0]  ALU_OP,
    output logic        S,
    output logic        C,
    output logic        V,
    input  logic [31:0] alu_F,
    input  logic [3:0]  alu_NZCV,
    output logic [3:0]  rn_addr,
    output logic [3:0]  rm_addr,
    output logic [3:0]  rd_addr,
    output logic        op_imm,
    output logic [11:0] imm12,
    output logic        rf_we,
    output logic [31:0] rf_wdata,
    output logic [3:0]  cpsr_nzcv,
    output logic        done,
    output logic        executed,
    output logic        illegal
);
    state_t      r_state, w_next;
    logic [31:0] r_ir, r_f;
    logic [3:0]  r_flags, r_cpsr, w_opc, w_alu_op;
    logic        w_legal, w_cond_ok, w_pass, w_cmp, w_s;
    assign w_opc     = r_ir[24:21];
    assign w_legal   = r_ir[27:26] == 2'b00;
    assign w_cmp     = w_opc[3:2] == 2'b10;
    assign w_s       = r_ir[20] | w_cmp;
    assign w_pass    = w_legal & w_cond_ok;
    assign w_alu_op  = !w_cmp ? w_opc : (w_opc[1:0] == 2'b11) ? ALU_ADD : {2'b00, w_opc[1:0]};
    assign rn_addr   = r_ir[19:16];
    assign rm_addr   = r_ir[3:0];
    assign rd_addr   = r_ir[15:12];
    assign op_imm    = r_ir[25];
    assign imm12     = r_ir[11:0];
    assign rf_wdata  = r_f;
    assign cpsr_nzcv = r_cpsr;
    assign C         = r_cpsr[FLAG_C];
    assign V         = r_cpsr[FLAG_V];
    cond_eval u_cond (
        .cond (r_ir[31:28]),
        .nzcv (r_cpsr),
        .pass (w_cond_ok)
    );
    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end
    // Instruction, ALU result/flag latches and architectural flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ir    <= '0;
            r_f     <= '0;
            r_flags <= '0;
            r_cpsr  <= '0;
        end else begin
            if (r_state == ST_IDLE && ir_valid) r_ir <= ir;
            if (r_state == ST_EXEC) begin
                r_f     <= alu_F;
                r_flags <= alu_NZCV;
            end
            if (r_state == ST_WB && w_pass && w_s) r_cpsr <= r_flags;
        end
    end
    // Next state and per-state outputs; failed/illegal instructions bypass EXEC
    always_comb begin
        w_next   = r_state;
        ir_ready = 1'b0;
        ALU_OP   = ALU_AND;
        S        = 1'b0;
        done     = 1'b0;
        executed = 1'b0;
        illegal  = 1'b0;
        rf_we    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                ir_ready = 1'b1;
                if (ir_valid) w_next = ST_DECODE;
            end
            ST_DECODE: w_next = w_pass ? ST_EXEC : ST_WB;
            ST_EXEC: begin
                ALU_OP = w_alu_op;
                S      = w_s;
                w_next = ST_WB;
            end
            ST_WB: begin
                done     = 1'b1;
                executed = w_pass;
                illegal  = !w_legal;
                rf_we    = w_pass & !w_cmp;
                w_next   = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_dp_ctrl.sv
// tb_dp_ctrl: scoreboard bench for dp_ctrl
module tb_dp_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ir_valid = 1'b0;
    logic [31:0] ir = '0;
    logic        ir_ready;
    logic [3:0]  ALU_OP;
    logic        S, C, V;
    logic [31:0] alu_F = '0;
    logic [3:0]  alu_NZCV = '0;
    logic [3:0]  rn_addr, rm_addr, rd_addr;
    logic        op_imm;
    logic [11:0] imm12;
    logic        rf_we;
    logic [31:0] rf_wdata;
    logic [3:0]  cpsr_nzcv;
    logic        done, executed, illegal;

    typedef struct {
        logic        ex;
        logic        il;
        logic        we;
        logic [3:0]  rd;
        logic [31:0] wd;
        logic [3:0]  cpsr;
    } exp_t;
    exp_t sb[$];
    int total = 0;
    int bad = 0;
    int n_done = 0;

    localparam logic [31:0] I_ADDS  = 32'hE0921003;
    localparam logic [31:0] I_CMP   = 32'hE1500001;
    localparam logic [31:0] I_MOVEQ = 32'h01A02003;
    localparam logic [31:0] I_ILL   = 32'hEA000000;

    dp_ctrl dut (
        .clk(clk), .rst_n(rst_n), .ir_valid(ir_valid), .ir(ir), .ir_ready(ir_ready),
        .ALU_OP(ALU_OP), .S(S), .C(C), .V(V), .alu_F(alu_F), .alu_NZCV(alu_NZCV),
        .rn_addr(rn_addr), .rm_addr(rm_addr), .rd_addr(rd_addr), .op_imm(op_imm),
        .imm12(imm12), .rf_we(rf_we), .rf_wdata(rf_wdata), .cpsr_nzcv(cpsr_nzcv),
        .done(done), .executed(executed), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Scoreboard: each done pulse retires the oldest expectation; flags are checked one cycle later
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                n_done++;
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL wb_unexpected: done=1 with no pending instruction");
                end else begin
                    e = sb.pop_front();
                    if ({executed, illegal, rf_we} !== {e.ex, e.il, e.we}) begin
                        bad++;
                        $display("FAIL wb_status: exec/ill/we=%b%b%b want %b%b%b", executed, illegal, rf_we, e.ex, e.il, e.we);
                    end
                    if (e.we) begin
                        total++;
                        if ({rd_addr, rf_wdata} !== {e.rd, e.wd}) begin
                            bad++;
                            $display("FAIL wb_data: rd=%0d wdata=%h want rd=%0d wdata=%h", rd_addr, rf_wdata, e.rd, e.wd);
                        end
                    end
                    @(negedge clk);
                    total++;
                    if (cpsr_nzcv !== e.cpsr) begin
                        bad++;
                        $display("FAIL wb_cpsr: cpsr=%b want %b", cpsr_nzcv, e.cpsr);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic push(input logic ex, il, we, input logic [3:0] rd, input logic [31:0] wd, input logic [3:0] cpsr);
        exp_t e;
        e.ex = ex; e.il = il; e.we = we; e.rd = rd; e.wd = wd; e.cpsr = cpsr;
        sb.push_back(e);
    endtask

    // Handshake one word; returns at the negedge of the DECODE cycle
    task automatic send(input logic [31:0] w, input logic [31:0] f, input logic [3:0] fl);
        int n = 0;
        @(negedge clk);
        while (ir_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (ir_ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL send_timeout: ir_ready=%b want 1", ir_ready);
        end
        ir = w; ir_valid = 1'b1; alu_F = f; alu_NZCV = fl;
        @(negedge clk);
        ir_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++;
        if ({ir_ready, ALU_OP, S, rf_we, rf_wdata, done, executed, illegal, cpsr_nzcv, rd_addr} !== {1'b1, 4'h0, 1'b0, 1'b0, 32'h0, 3'b000, 4'h0, 4'h0}) begin
            bad++;
            $display("FAIL reset_values: ready=%b op=%h S=%b we=%b wd=%h done=%b ex=%b ill=%b cpsr=%b rd=%h", ir_ready, ALU_OP, S, rf_we, rf_wdata, done, executed, illegal, cpsr_nzcv, rd_addr);
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (ir_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: ir_ready=%b want 1", ir_ready); end
    endtask

    task automatic test_adds();
        send(I_ADDS, 32'd5, 4'b0000);
        push(1, 0, 1, 4'd1, 32'd5, 4'b0000);
        total++;
        if ({rn_addr, rm_addr, rd_addr, op_imm, imm12, ir_ready} !== {4'd2, 4'd3, 4'd1, 1'b0, 12'h003, 1'b0}) begin
            bad++;
            $display("FAIL adds_decode: rn=%h rm=%h rd=%h imm=%b imm12=%h ready=%b", rn_addr, rm_addr, rd_addr, op_imm, imm12, ir_ready);
        end
        @(negedge clk);
        total++;
        if ({ALU_OP, S} !== {4'h4, 1'b1}) begin bad++; $display("FAIL adds_exec: op=%h S=%b want 4 1", ALU_OP, S); end
        @(negedge clk);
        total++;
        if ({done, rf_we, rf_wdata} !== {1'b1, 1'b1, 32'd5}) begin bad++; $display("FAIL adds_wb: done=%b we=%b wd=%h want 1 1 5", done, rf_we, rf_wdata); end
        @(negedge clk);
        total++;
        if (ir_ready !== 1'b1) begin bad++; $display("FAIL adds_idle: ir_ready=%b want 1", ir_ready); end
    endtask

    task automatic test_cmp_moveq();
        send(I_CMP, 32'h1234, 4'b0100);
        push(1, 0, 0, 4'd0, 32'h0, 4'b0100);
        @(negedge clk);
        total++;
        if ({ALU_OP, S} !== {4'h2, 1'b1}) begin bad++; $display("FAIL cmp_exec: op=%h S=%b want 2 1", ALU_OP, S); end
        repeat (2) @(negedge clk);
        total++;
        if ({cpsr_nzcv, C, V} !== {4'b0100, 1'b0, 1'b0}) begin bad++; $display("FAIL cmp_flags: cpsr=%b C=%b V=%b want 0100 0 0", cpsr_nzcv, C, V); end
        send(I_MOVEQ, 32'hABCD, 4'b1111);
        push(1, 0, 1, 4'd2, 32'hABCD, 4'b0100);
        @(negedge clk);
        total++;
        if ({ALU_OP, S} !== {4'hD, 1'b0}) begin bad++; $display("FAIL moveq_exec: op=%h S=%b want d 0", ALU_OP, S); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_moveq_fail();
        send(I_ADDS, 32'h11, 4'b0000);
        push(1, 0, 1, 4'd1, 32'h11, 4'b0000);
        repeat (3) @(negedge clk);
        send(I_MOVEQ, 32'hFFFF, 4'b1111);
        push(0, 0, 0, 4'd2, 32'h0, 4'b0000);
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL nv_decode: done=%b want 0", done); end
        @(negedge clk);
        total++;
        if ({done, executed, rf_we, ALU_OP, S} !== {1'b1, 1'b0, 1'b0, 4'h0, 1'b0}) begin
            bad++;
            $display("FAIL nv_skip: done=%b ex=%b we=%b op=%h S=%b want 1 0 0 0 0", done, executed, rf_we, ALU_OP, S);
        end
        @(negedge clk);
        total++;
        if ({ir_ready, rf_wdata} !== {1'b1, 32'h11}) begin bad++; $display("FAIL nv_idle: ready=%b wd=%h want 1 11", ir_ready, rf_wdata); end
    endtask

    task automatic test_illegal();
        send(I_ILL, 32'h55, 4'b1111);
        push(0, 1, 0, 4'd0, 32'h0, 4'b0000);
        total++;
        if (ir_ready !== 1'b0) begin bad++; $display("FAIL ill_decode: ready=%b want 0", ir_ready); end
        @(negedge clk);
        total++;
        if ({done, illegal, executed, rf_we} !== 4'b1100) begin bad++; $display("FAIL ill_wb: done/ill/ex/we=%b%b%b%b want 1100", done, illegal, executed, rf_we); end
        @(negedge clk);
        total++;
        if (ir_ready !== 1'b1) begin bad++; $display("FAIL ill_idle: ready=%b want 1", ir_ready); end
    endtask

    task automatic test_back_to_back();
        int hs = 0;
        int cyc = 0;
        int last = 0;
        int n0 = n_done;
        @(negedge clk);
        ir = I_ADDS; ir_valid = 1'b1; alu_F = 32'd9; alu_NZCV = 4'b0011;
        while (hs < 3 && cyc < 40) begin
            if (ir_ready === 1'b1) begin
                hs++;
                push(1, 0, 1, 4'd1, 32'd9, 4'b0011);
                if (hs > 1) begin
                    total++;
                    if (cyc - last != 4) begin bad++; $display("FAIL b2b_interval: gap=%0d want 4", cyc - last); end
                end
                last = cyc;
            end
            @(negedge clk);
            cyc++;
        end
        ir_valid = 1'b0;
        repeat (6) @(negedge clk);
        total++;
        if (n_done - n0 != 3 || hs != 3) begin bad++; $display("FAIL b2b_count: done pulses=%0d handshakes=%0d want 3 3", n_done - n0, hs); end
        total++;
        if ({cpsr_nzcv, C, V} !== {4'b0011, 1'b1, 1'b1}) begin bad++; $display("FAIL b2b_flags: cpsr=%b C=%b V=%b want 0011 1 1", cpsr_nzcv, C, V); end
    endtask

    task automatic test_reset_mid();
        logic we_seen = 1'b0;
        send(I_ADDS, 32'd7, 4'b1100);
        @(negedge clk);
        total++;
        if (ALU_OP !== 4'h4) begin bad++; $display("FAIL rst_exec: op=%h want 4", ALU_OP); end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({ir_ready, cpsr_nzcv, rf_we, rf_wdata, done, C, V} !== {1'b1, 4'b0000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL rst_abort: ready=%b cpsr=%b we=%b wd=%h done=%b C=%b V=%b", ir_ready, cpsr_nzcv, rf_we, rf_wdata, done, C, V);
        end
        repeat (4) begin
            @(negedge clk);
            if (rf_we !== 1'b0) we_seen = 1'b1;
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (rf_we !== 1'b0 || done !== 1'b0) we_seen = 1'b1;
        end
        total++;
        if (we_seen || cpsr_nzcv !== 4'b0000 || ir_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_after: write_seen=%b cpsr=%b ready=%b want 0 0000 1", we_seen, cpsr_nzcv, ir_ready);
        end
    endtask

    initial begin
        test_reset();
        test_adds();
        test_cmp_moveq();
        test_moveq_fail();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL sb_drain: pending=%0d want 0", sb.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
